// File: rtl/axi_slice_dc_pkg.sv
// Shared types and sizing helpers for the dual-clock AXI slice power controller.
package axi_slice_dc_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    DRAIN   = 3'd1,
    ISOLATE = 3'd2,
    SLEEP   = 3'd3,
    WAKE    = 3'd4
  } pwr_state_e;

  // Bits needed to count 0 .. max_count-1 (at least one bit).
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

  localparam int DRAIN_TIMEOUT_DEF = 1024;
  localparam int WAKE_CYCLES_DEF   = 4;
  localparam int TMO_CNT_W         = cnt_width(DRAIN_TIMEOUT_DEF);
  localparam int WAKE_CNT_W        = cnt_width(WAKE_CYCLES_DEF);

endpackage

// File: rtl/axi_slice_dc_outstanding_cnt.sv
// Saturating outstanding-transaction counter with a sticky over/underflow flag.
module axi_slice_dc_outstanding_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         err
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
      err   <= 1'b0;
    end else if (inc && !dec) begin
      if (count == {W{1'b1}}) err <= 1'b1;
      else                    count <= count + W'(1);
    end else if (dec && !inc) begin
      if (count == '0) err <= 1'b1;
      else             count <= count - W'(1);
    end
  end

endmodule

// File: rtl/axi_slice_dc_pwr_ctrl.sv
// Drain/isolate/sleep sequencer driving clock_down and isolate of the master-side
// dual-clock AXI slice, plus the enable for its downstream clock gate.
module axi_slice_dc_pwr_ctrl
  import axi_slice_dc_pkg::*;
#(
  parameter int CNT_WIDTH     = 8,
  parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
  parameter int WAKE_CYCLES   = WAKE_CYCLES_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 iso_req_i,
  input  logic                 sleep_req_i,
  input  logic                 incoming_req_i,
  input  logic                 aw_hs_i,
  input  logic                 ar_hs_i,
  input  logic                 b_hs_i,
  input  logic                 r_last_hs_i,
  output logic                 clock_down_o,
  output logic                 isolate_o,
  output logic                 clk_en_o,
  output logic                 ack_o,
  output logic [CNT_WIDTH-1:0] wr_outstanding_o,
  output logic [CNT_WIDTH-1:0] rd_outstanding_o,
  output logic                 timeout_o,
  output logic                 cnt_err_o,
  output logic [2:0]           state_o
);

  localparam int TMO_W  = cnt_width(DRAIN_TIMEOUT);
  localparam int WAKE_W = cnt_width(WAKE_CYCLES);
  localparam bit TMO_EN = (DRAIN_TIMEOUT != 0);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_EN ? TMO_W'(DRAIN_TIMEOUT - 1) : '0;
  localparam logic [WAKE_W-1:0] WAKE_LAST = (WAKE_CYCLES < 1) ? '0 : WAKE_W'(WAKE_CYCLES - 1);

  pwr_state_e        state_q, state_d;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [WAKE_W-1:0] wake_cnt_q;
  logic              timeout_q;
  logic              tmo_fire;
  logic              wr_err, rd_err;
  logic              idle;

  axi_slice_dc_outstanding_cnt #(.W(CNT_WIDTH)) u_wr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (aw_hs_i),
    .dec    (b_hs_i),
    .count  (wr_outstanding_o),
    .err    (wr_err)
  );

  axi_slice_dc_outstanding_cnt #(.W(CNT_WIDTH)) u_rd_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (ar_hs_i),
    .dec    (r_last_hs_i),
    .count  (rd_outstanding_o),
    .err    (rd_err)
  );

  assign idle = (wr_outstanding_o == '0) && (rd_outstanding_o == '0);

  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    unique case (state_q)
      RUN: begin
        if (iso_req_i || sleep_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!iso_req_i && !sleep_req_i) begin
          state_d = RUN;
        end else if (idle && iso_req_i) begin
          state_d = ISOLATE;
        end else if (idle) begin
          state_d = SLEEP;
        end else if (TMO_EN && (tmo_cnt_q == TMO_LAST) && iso_req_i) begin
          // Sleep-only requests never get here: they wait for idle indefinitely.
          state_d  = ISOLATE;
          tmo_fire = 1'b1;
        end
      end
      ISOLATE: begin
        if (!iso_req_i) state_d = WAKE;
      end
      SLEEP: begin
        if (iso_req_i)                            state_d = ISOLATE;
        else if (!sleep_req_i || incoming_req_i)  state_d = WAKE;
      end
      WAKE: begin
        if (wake_cnt_q == WAKE_LAST) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      tmo_cnt_q  <= '0;
      wake_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Holding at the terminal value keeps a long sleep-only drain able to time
      // out as soon as an isolate request joins it.
      if (state_q == DRAIN && state_d == DRAIN)
        tmo_cnt_q <= (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
      else
        tmo_cnt_q <= '0;
      if (state_q == WAKE && state_d == WAKE)
        wake_cnt_q <= wake_cnt_q + WAKE_W'(1);
      else
        wake_cnt_q <= '0;
      if (tmo_fire) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    clock_down_o = 1'b0;
    isolate_o    = 1'b0;
    clk_en_o     = 1'b1;
    ack_o        = 1'b0;
    unique case (state_q)
      RUN: ;
      DRAIN: clock_down_o = 1'b1;
      ISOLATE: begin
        clock_down_o = 1'b1;
        isolate_o    = 1'b1;
        ack_o        = 1'b1;
      end
      SLEEP: begin
        clock_down_o = 1'b1;
        clk_en_o     = 1'b0;
        ack_o        = 1'b1;
      end
      WAKE: clock_down_o = 1'b1;
      default: ;
    endcase
  end

  assign timeout_o = timeout_q;
  assign cnt_err_o = wr_err | rd_err;
  assign state_o   = state_q;

endmodule

// File: tb/tb_axi_slice_dc_pwr_ctrl.sv
// Randomised and directed stimulus for the slice power controller, checked cycle by
// cycle against a behavioural model through an expected-output queue.
module tb_axi_slice_dc_pwr_ctrl;

  localparam int CW     = 3;
  localparam int TMO    = 16;
  localparam int WAKE_N = 4;
  localparam int MAXC   = (1 << CW) - 1;
  localparam int OUT_W  = 4 + 2 * CW + 2;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic iso_req_i = 1'b0, sleep_req_i = 1'b0, incoming_req_i = 1'b0;
  logic aw_hs_i = 1'b0, ar_hs_i = 1'b0, b_hs_i = 1'b0, r_last_hs_i = 1'b0;
  logic clock_down_o, isolate_o, clk_en_o, ack_o, timeout_o, cnt_err_o;
  logic [CW-1:0] wr_outstanding_o, rd_outstanding_o;
  logic [2:0] state_o;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  axi_slice_dc_pwr_ctrl #(
    .CNT_WIDTH(CW), .DRAIN_TIMEOUT(TMO), .WAKE_CYCLES(WAKE_N)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .iso_req_i(iso_req_i), .sleep_req_i(sleep_req_i), .incoming_req_i(incoming_req_i),
    .aw_hs_i(aw_hs_i), .ar_hs_i(ar_hs_i), .b_hs_i(b_hs_i), .r_last_hs_i(r_last_hs_i),
    .clock_down_o(clock_down_o), .isolate_o(isolate_o), .clk_en_o(clk_en_o), .ack_o(ack_o),
    .wr_outstanding_o(wr_outstanding_o), .rd_outstanding_o(rd_outstanding_o),
    .timeout_o(timeout_o), .cnt_err_o(cnt_err_o), .state_o(state_o)
  );

  wire [OUT_W-1:0] dut_outs = {clock_down_o, isolate_o, clk_en_o, ack_o,
                               wr_outstanding_o, rd_outstanding_o, timeout_o, cnt_err_o};

  // ---------------- reference model ----------------
  string m_st;
  int    m_wr, m_rd, m_drain, m_wake;
  bit    m_tmo, m_err;

  function automatic void model_reset();
    m_st = "RUN"; m_wr = 0; m_rd = 0; m_drain = 0; m_wake = 0; m_tmo = 0; m_err = 0;
  endfunction

  function automatic logic [OUT_W-1:0] model_outs();
    logic cd, iso, ce, ack;
    cd  = (m_st != "RUN");
    iso = (m_st == "ISOLATE");
    ce  = (m_st != "SLEEP");
    ack = (m_st == "ISOLATE") || (m_st == "SLEEP");
    return {cd, iso, ce, ack, CW'(m_wr), CW'(m_rd), m_tmo, m_err};
  endfunction

  function automatic void bump(inout int c, inout bit err, input bit inc, input bit dec);
    if (inc && !dec) begin
      if (c == MAXC) err = 1'b1; else c = c + 1;
    end else if (dec && !inc) begin
      if (c == 0) err = 1'b1; else c = c - 1;
    end
  endfunction

  function automatic void model_step(input bit iso, sleep, inc, aw, ar, b, rl);
    bit    idle;
    string nx;
    idle = (m_wr == 0) && (m_rd == 0);
    nx   = m_st;
    case (m_st)
      "RUN":     if (iso || sleep) nx = "DRAIN";
      "DRAIN": begin
        if (!iso && !sleep)                  nx = "RUN";
        else if (idle && iso)                nx = "ISOLATE";
        else if (idle)                       nx = "SLEEP";
        else if (iso && m_drain >= TMO - 1) begin
          nx = "ISOLATE"; m_tmo = 1'b1;
        end
      end
      "ISOLATE": if (!iso) nx = "WAKE";
      "SLEEP": begin
        if (iso)                 nx = "ISOLATE";
        else if (!sleep || inc)  nx = "WAKE";
      end
      "WAKE":    if (m_wake + 1 >= WAKE_N) nx = "RUN";
      default:   nx = "RUN";
    endcase
    m_drain = (m_st == "DRAIN" && nx == "DRAIN") ? m_drain + 1 : 0;
    m_wake  = (m_st == "WAKE" && nx == "WAKE") ? m_wake + 1 : 0;
    bump(m_wr, m_err, aw, b);
    bump(m_rd, m_err, ar, rl);
    m_st = nx;
  endfunction

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] exp_v;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk_i) begin
    cyc = cyc + 1;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_tests = n_tests + 1;
      if (dut_outs !== exp_v) begin
        n_fail = n_fail + 1;
        $display("FAIL outputs cycle %0d got %b required %b (cd,iso,clk_en,ack,wr,rd,tmo,err)",
                 cyc, dut_outs, exp_v);
      end
    end
  end

  task automatic check_reset(input string name);
    logic [OUT_W-1:0] rv;
    rv = {4'b0010, {(2 * CW + 2){1'b0}}};
    n_tests = n_tests + 1;
    if (dut_outs !== rv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got %b required %b", name, dut_outs, rv);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit iso, sleep, inc, aw, ar, b, rl);
    @(negedge clk_i);
    iso_req_i = iso; sleep_req_i = sleep; incoming_req_i = inc;
    aw_hs_i = aw; ar_hs_i = ar; b_hs_i = b; r_last_hs_i = rl;
    model_step(iso, sleep, inc, aw, ar, b, rl);
    exp_q.push_back(model_outs());
  endtask

  task automatic zero_inputs();
    iso_req_i = 0; sleep_req_i = 0; incoming_req_i = 0;
    aw_hs_i = 0; ar_hs_i = 0; b_hs_i = 0; r_last_hs_i = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mode, len;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 check_reset("reset_values");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // idle, then balanced writes
    repeat (10) step(0, 0, 0, 0, 0, 0, 0);
    repeat (3)  step(0, 0, 0, 1, 0, 0, 0);
    repeat (3)  step(0, 0, 0, 0, 0, 1, 0);

    // drain to isolate with two writes outstanding, then wake
    repeat (2)  step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (2)  step(1, 0, 0, 0, 0, 1, 0);
    repeat (3)  step(1, 0, 0, 0, 0, 0, 0);
    repeat (7)  step(0, 0, 0, 0, 0, 0, 0);

    // drain timeout with one read never returned
    step(0, 0, 0, 0, 1, 0, 0);
    repeat (20) step(1, 0, 0, 0, 0, 0, 0);
    repeat (6)  step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // sleep then wake on incoming request
    repeat (3)  step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    repeat (5)  step(0, 1, 0, 0, 0, 0, 0);
    repeat (7)  step(0, 0, 0, 0, 0, 0, 0);

    // simultaneous handshakes and requests
    repeat (5)  step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    repeat (5)  step(0, 0, 0, 0, 0, 1, 0);
    repeat (4)  step(1, 1, 0, 0, 0, 0, 0);
    repeat (6)  step(0, 0, 0, 0, 0, 0, 0);
    repeat (3)  step(0, 1, 0, 0, 0, 0, 0);
    repeat (3)  step(1, 1, 0, 0, 0, 0, 0);
    repeat (7)  step(0, 0, 0, 0, 0, 0, 0);

    // underflow and overflow
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (MAXC + 1) step(0, 0, 0, 1, 0, 0, 0);
    repeat (MAXC)     step(0, 0, 0, 0, 0, 1, 0);

    // asynchronous reset while sleeping
    repeat (4) step(0, 1, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1 check_reset("async_reset");
    model_reset();
    @(negedge clk_i);
    zero_inputs();
    rst_ni = 1'b1;

    // randomised request phases with background traffic
    for (int p = 0; p < 60; p++) begin
      mode = $urandom_range(0, 3);
      len  = $urandom_range(1, 30);
      for (int k = 0; k < len; k++) begin
        step(mode[0], mode[1], $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             (m_wr > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0),
             (m_rd > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0));
      end
    end
    repeat (8) step(0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk_i);
    #2;
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL queue_drained got %0d entries required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
